rename_tag_alloc: RTL and testbench
===================================

# rename_tag_alloc

Physical-tag allocator and reclaim controller for the rename stage. It owns the per-tag state (free / speculative / committed) of all physical register tags and pre-selects up to two free tags per cycle for the rename lanes. Commit-side frees and branch-misprediction reclaim are applied in the same update, so rename reads registered candidates instead of scanning 64 entries. It sits between Rename, the ROB commit port and the branch unit.

## Interface
- `NUM_TAGS`, 64, number of physical tags; index width is 6.
- `NUM_ARCH`, 32, architectural registers; tags `0..NUM_ARCH-1` start committed.
- `WIDTH_ALLOC`, 2, rename lanes.
- `WIDTH_COM`, 2, commit lanes.

- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `IN_allocReq[WIDTH_ALLOC]`  in  1 each  lane requests a tag this cycle.
- `IN_allocSqN[WIDTH_ALLOC]`  in  6 each  sqN of the requesting uop.
- `OUT_allocTag[WIDTH_ALLOC]`  out  6 each  registered candidate tags.
- `OUT_allocReady`  out  1  number of valid candidates ≥ `WIDTH_ALLOC`.
- `IN_comValid[WIDTH_COM]`  in  1 each  commit of a uop with rd≠0.
- `IN_comTag[WIDTH_COM]`  in  6 each  tag that becomes committed.
- `IN_comPrevTag[WIDTH_COM]`  in  6 each  previous committed tag of that rd, freed.
- `IN_comSqN[WIDTH_COM]`  in  6 each  sqN of the committing uop.
- `IN_branchTaken`  in  1  misprediction recovery this cycle.
- `IN_branchSqN`  in  6  sqN of the mispredicted branch.
- `OUT_freeCount`  out  7  registered count of FREE tags.
- `OUT_error`  out  1  sticky protocol-error flag.

## Operation
- Per-tag state is one of FREE, SPEC or COMMITTED, plus a 6-bit sqN that is valid in SPEC.
- Reset:
  - tags `0..31` become COMMITTED and tags `32..63` become FREE;
  - `OUT_freeCount` = 32; `OUT_allocTag` = {32, 33}; `OUT_allocReady` = 1; `OUT_error` = 0.
- Allocation (only when `!IN_branchTaken`):
  - Lane i takes candidate k, where k is the number of requesting lanes below i. Requests need not be compacted.
  - The granted tag goes to SPEC with sqN = `IN_allocSqN[i]`.
  - A request while the corresponding candidate is invalid is ignored and sets `OUT_error`.
- Commit is processed lane 0 then lane 1; for a write to the same tag, the later lane wins:
  - `IN_comTag` goes to COMMITTED;
  - `IN_comPrevTag` goes to FREE.
  - Freeing a tag that is already FREE sets `OUT_error`.
  - This ordering lets the ROB kill an overwritten same-cycle commit by presenting lane 1 prevTag = lane 0 tag.
- Branch recovery (`IN_branchTaken`):
  - Every SPEC tag with `$signed(sqN - IN_branchSqN) > 0` goes to FREE.
  - All allocation requests that cycle are dropped.
  - A commit lane is applied only if `$signed(IN_comSqN - IN_branchSqN) <= 0`.
- Candidate selection runs on the next-state vector: the lowest and second-lowest FREE indices are registered into `OUT_allocTag[0]` / `OUT_allocTag[1]` with valid bits.
  - `OUT_allocReady` = both valid.
  - `OUT_freeCount` = popcount of the next-state FREE bits.
- sqN arithmetic is mod 64 with a signed difference. At most 32 uops may be in flight.

## Timing
- Candidates are registered, with 0-cycle grant latency: a tag presented in cycle n is granted in cycle n, and becomes SPEC after edge n.
- A tag freed at edge n (commit or recovery) can appear as a candidate from cycle n+1.
- A tag granted in cycle n never appears as a candidate in cycle n+1.
- `OUT_freeCount` reflects all updates of cycle n from cycle n+1.
- Empty: with 1 FREE tag, `OUT_allocReady` = 0 and `OUT_allocTag[0]` is valid. Rename must stall; a single-lane grant is still legal.
- Full: 64 FREE tags cannot occur in normal operation, because 32 tags are always COMMITTED.
- Branch and commit in the same cycle:
  - older commits are applied and younger ones are discarded;
  - a prevTag free and a recovery free of different tags combine.
- `rst` mid-operation overrides all inputs that cycle and restores the reset state at the next edge.

## Structure
- Shared package holds:
  - `TagState_t` enum {FREE, SPEC, COMMITTED};
  - `NUM_TAGS`;
  - `NUM_ARCH`;
  - the `sqn_younger(a,b)` function.
- One sub-module, `prio_enc2`: a combinational encoder that returns the two lowest set indices of a 64-bit vector with valid bits.
- No other hierarchy.

## Test plan
- Reset, then grant both lanes → tags 32, 33; next cycle the candidates are {34, 35} and `OUT_freeCount` = 30.
- Only lane 1 requests → lane 1 receives 32; next cycle the candidates are {33, 34}.
- Allocate sqN 5..20 (tags 32..47), then branch with `IN_branchSqN` = 10 → tags 38..47 become FREE; `OUT_freeCount` goes from 16 to 26 one cycle later.
- Same-cycle commit: lane 0 commits tag 40 (prev 3); lane 1 commits tag 41 (prev 40) → tags 3 and 40 are FREE, tag 41 is COMMITTED.
- Allocate 31 tags, then request 2 → `OUT_allocReady` = 0; lane 0 alone is granted the last tag; a further lane-0 request sets `OUT_error`.
- Branch with `IN_branchSqN` = 60 while the commit lanes carry sqN 59 and 61 → only the sqN-59 commit is applied.

Source files
------------

// File: rtl/rename_tag_alloc_pkg.sv
// Shared types and helpers for the rename physical-tag allocator.
package rename_tag_alloc_pkg;

  localparam int NUM_TAGS    = 64;
  localparam int NUM_ARCH    = 32;
  localparam int WIDTH_ALLOC = 2;
  localparam int WIDTH_COM   = 2;
  localparam int TAG_W       = 6;
  localparam int SQN_W       = 6;

  typedef logic [TAG_W-1:0] Tag_t;
  typedef logic [SQN_W-1:0] SqN_t;

  typedef enum logic [1:0] {
    FREE      = 2'd0,
    SPEC      = 2'd1,
    COMMITTED = 2'd2
  } TagState_t;

  // True when a is strictly younger than b in the mod-64 sqN window.
  function automatic logic sqn_younger(input SqN_t a, input SqN_t b);
    SqN_t diff;
    diff = a - b;
    return ($signed(diff) > 0);
  endfunction

endpackage

// File: rtl/rename_tag_alloc_if.sv
// Rename / ROB-commit / branch-unit bundle seen by the tag allocator.
interface rename_tag_alloc_if;
  import rename_tag_alloc_pkg::*;

  logic IN_allocReq   [WIDTH_ALLOC];
  SqN_t IN_allocSqN   [WIDTH_ALLOC];
  Tag_t OUT_allocTag  [WIDTH_ALLOC];
  logic OUT_allocReady;

  logic IN_comValid   [WIDTH_COM];
  Tag_t IN_comTag     [WIDTH_COM];
  Tag_t IN_comPrevTag [WIDTH_COM];
  SqN_t IN_comSqN     [WIDTH_COM];

  logic IN_branchTaken;
  SqN_t IN_branchSqN;

  logic [6:0] OUT_freeCount;
  logic       OUT_error;

  modport master (
    output IN_allocReq, IN_allocSqN, IN_comValid, IN_comTag, IN_comPrevTag,
           IN_comSqN, IN_branchTaken, IN_branchSqN,
    input  OUT_allocTag, OUT_allocReady, OUT_freeCount, OUT_error
  );

  modport slave (
    input  IN_allocReq, IN_allocSqN, IN_comValid, IN_comTag, IN_comPrevTag,
           IN_comSqN, IN_branchTaken, IN_branchSqN,
    output OUT_allocTag, OUT_allocReady, OUT_freeCount, OUT_error
  );
endinterface

// File: rtl/rename_tag_alloc_prio_enc2.sv
// Returns the lowest and second-lowest set indices of a vector, with valid bits.
module prio_enc2 #(
  parameter int N = 64,
  parameter int W = 6
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx0,
  output logic         valid0,
  output logic [W-1:0] idx1,
  output logic         valid1
);

  always_comb begin
    idx0   = '0;
    idx1   = '0;
    valid0 = 1'b0;
    valid1 = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        if (!valid0) begin
          idx0   = W'(i);
          valid0 = 1'b1;
        end else if (!valid1) begin
          idx1   = W'(i);
          valid1 = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rename_tag_alloc.sv
// Physical-tag state owner: grants pre-selected free tags, applies commits and
// misprediction reclaim, and registers the next two candidates.
module rename_tag_alloc
  import rename_tag_alloc_pkg::*;
(
  input logic              clk,
  input logic              rst,
  rename_tag_alloc_if.slave bus
);

  TagState_t  tagState [NUM_TAGS];
  SqN_t       tagSqN   [NUM_TAGS];
  Tag_t       candTag  [WIDTH_ALLOC];
  logic       candValid[WIDTH_ALLOC];
  logic [6:0] freeCount;
  logic       error;

  TagState_t     stNext [NUM_TAGS];
  SqN_t          sqNext [NUM_TAGS];
  logic          errNext;
  logic [NUM_TAGS-1:0] freeVec;
  logic [6:0]    cntNext;
  logic          slot;
  Tag_t          encIdx0, encIdx1;
  logic          encValid0, encValid1;

  // Order matters: recovery, then commit lanes in order, then grants.
  always_comb begin
    stNext  = tagState;
    sqNext  = tagSqN;
    errNext = error;
    slot    = 1'b0;

    if (bus.IN_branchTaken) begin
      for (int t = 0; t < NUM_TAGS; t++) begin
        if (tagState[t] == SPEC && sqn_younger(tagSqN[t], bus.IN_branchSqN))
          stNext[t] = FREE;
      end
    end

    for (int c = 0; c < WIDTH_COM; c++) begin
      if (bus.IN_comValid[c] &&
          (!bus.IN_branchTaken || !sqn_younger(bus.IN_comSqN[c], bus.IN_branchSqN))) begin
        stNext[bus.IN_comTag[c]] = COMMITTED;
        if (stNext[bus.IN_comPrevTag[c]] == FREE)
          errNext = 1'b1;
        stNext[bus.IN_comPrevTag[c]] = FREE;
      end
    end

    if (!bus.IN_branchTaken) begin
      for (int i = 0; i < WIDTH_ALLOC; i++) begin
        if (bus.IN_allocReq[i]) begin
          if (candValid[slot]) begin
            stNext[candTag[slot]] = SPEC;
            sqNext[candTag[slot]] = bus.IN_allocSqN[i];
          end else begin
            errNext = 1'b1;
          end
          slot = 1'b1;
        end
      end
    end
  end

  always_comb begin
    freeVec = '0;
    cntNext = '0;
    for (int t = 0; t < NUM_TAGS; t++) begin
      freeVec[t] = (stNext[t] == FREE);
      cntNext    = cntNext + {6'b0, freeVec[t]};
    end
  end

  prio_enc2 #(.N(NUM_TAGS), .W(TAG_W)) u_prio_enc2 (
    .vec    (freeVec),
    .idx0   (encIdx0),
    .valid0 (encValid0),
    .idx1   (encIdx1),
    .valid1 (encValid1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < NUM_TAGS; t++) begin
        tagState[t] <= (t < NUM_ARCH) ? COMMITTED : FREE;
        tagSqN[t]   <= '0;
      end
      candTag[0]   <= Tag_t'(NUM_ARCH);
      candTag[1]   <= Tag_t'(NUM_ARCH + 1);
      candValid[0] <= 1'b1;
      candValid[1] <= 1'b1;
      freeCount    <= 7'(NUM_TAGS - NUM_ARCH);
      error        <= 1'b0;
    end else begin
      tagState     <= stNext;
      tagSqN       <= sqNext;
      candTag[0]   <= encIdx0;
      candTag[1]   <= encIdx1;
      candValid[0] <= encValid0;
      candValid[1] <= encValid1;
      freeCount    <= cntNext;
      error        <= errNext;
    end
  end

  assign bus.OUT_allocTag[0] = candTag[0];
  assign bus.OUT_allocTag[1] = candTag[1];
  assign bus.OUT_allocReady  = candValid[0] & candValid[1];
  assign bus.OUT_freeCount   = freeCount;
  assign bus.OUT_error       = error;

endmodule

// File: tb/tb_rename_tag_alloc.sv
// Directed bench for rename_tag_alloc with a per-tag reference model.
module tb_rename_tag_alloc;
  import rename_tag_alloc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rename_tag_alloc_if bus();
  rename_tag_alloc dut (.clk(clk), .rst(rst), .bus(bus));

  int nChecks = 0;
  int nPass   = 0;
  bit checkEn = 1'b0;

  // 0 = free, 1 = speculative, 2 = committed
  int mState [64];
  int mSqN   [64];
  bit mErr;
  int nState [64];
  int nSqN   [64];
  bit nErr;

  function automatic int mCand(input int k);
    int n = 0;
    for (int t = 0; t < 64; t++) begin
      if (mState[t] == 0) begin
        if (n == k) return t;
        n++;
      end
    end
    return -1;
  endfunction

  function automatic int mFreeCnt();
    int n = 0;
    for (int t = 0; t < 64; t++) if (mState[t] == 0) n++;
    return n;
  endfunction

  function automatic bit mYounger(input int a, input int b);
    int d = (a - b + 64) % 64;
    return (d >= 1) && (d <= 31);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic modelCompute();
    int k;
    int c;
    nState = mState;
    nSqN   = mSqN;
    nErr   = mErr;
    if (rst) begin
      for (int t = 0; t < 64; t++) begin
        nState[t] = (t < 32) ? 2 : 0;
        nSqN[t]   = 0;
      end
      nErr = 1'b0;
      return;
    end
    if (bus.IN_branchTaken) begin
      for (int t = 0; t < 64; t++)
        if (mState[t] == 1 && mYounger(mSqN[t], int'(bus.IN_branchSqN))) nState[t] = 0;
    end
    for (int l = 0; l < 2; l++) begin
      if (bus.IN_comValid[l] &&
          (!bus.IN_branchTaken || !mYounger(int'(bus.IN_comSqN[l]), int'(bus.IN_branchSqN)))) begin
        nState[int'(bus.IN_comTag[l])] = 2;
        if (nState[int'(bus.IN_comPrevTag[l])] == 0) nErr = 1'b1;
        nState[int'(bus.IN_comPrevTag[l])] = 0;
      end
    end
    if (!bus.IN_branchTaken) begin
      k = 0;
      for (int l = 0; l < 2; l++) begin
        if (bus.IN_allocReq[l]) begin
          c = mCand(k);
          if (c < 0) nErr = 1'b1;
          else begin
            nState[c] = 1;
            nSqN[c]   = int'(bus.IN_allocSqN[l]);
          end
          k++;
        end
      end
    end
  endtask

  task automatic clearIn();
    for (int l = 0; l < 2; l++) begin
      bus.IN_allocReq[l]   = 1'b0;
      bus.IN_allocSqN[l]   = '0;
      bus.IN_comValid[l]   = 1'b0;
      bus.IN_comTag[l]     = '0;
      bus.IN_comPrevTag[l] = '0;
      bus.IN_comSqN[l]     = '0;
    end
    bus.IN_branchTaken = 1'b0;
    bus.IN_branchSqN   = '0;
  endtask

  task automatic step();
    modelCompute();
    @(posedge clk);
    #1;
    mState = nState;
    mSqN   = nSqN;
    mErr   = nErr;
    clearIn();
  endtask

  task automatic doReset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic alloc2(input int s0, input int s1);
    bus.IN_allocReq[0] = 1'b1; bus.IN_allocSqN[0] = SqN_t'(s0);
    bus.IN_allocReq[1] = 1'b1; bus.IN_allocSqN[1] = SqN_t'(s1);
    step();
  endtask

  task automatic alloc1(input int lane, input int s);
    bus.IN_allocReq[lane] = 1'b1; bus.IN_allocSqN[lane] = SqN_t'(s);
    step();
  endtask

  task automatic commitLane(input int l, input int tag, input int prev, input int s);
    bus.IN_comValid[l]   = 1'b1;
    bus.IN_comTag[l]     = Tag_t'(tag);
    bus.IN_comPrevTag[l] = Tag_t'(prev);
    bus.IN_comSqN[l]     = SqN_t'(s);
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      if (mCand(0) >= 0) check("cmp_allocTag0", int'(bus.OUT_allocTag[0]), mCand(0));
      if (mCand(1) >= 0) check("cmp_allocTag1", int'(bus.OUT_allocTag[1]), mCand(1));
      check("cmp_allocReady", int'(bus.OUT_allocReady), int'(mCand(1) >= 0));
      check("cmp_freeCount", int'(bus.OUT_freeCount), mFreeCnt());
      check("cmp_error", int'(bus.OUT_error), int'(mErr));
    end
  end

  initial begin
    for (int t = 0; t < 64; t++) begin mState[t] = 0; mSqN[t] = 0; end
    mErr = 1'b0;
    clearIn();
    doReset();
    doReset();
    checkEn = 1'b1;

    check("rst_tag0", int'(bus.OUT_allocTag[0]), 32);
    check("rst_tag1", int'(bus.OUT_allocTag[1]), 33);
    check("rst_ready", int'(bus.OUT_allocReady), 1);
    check("rst_free", int'(bus.OUT_freeCount), 32);
    check("rst_error", int'(bus.OUT_error), 0);
    check("model_rst_free", mFreeCnt(), 32);

    alloc2(0, 1);
    check("both_tag0", int'(bus.OUT_allocTag[0]), 34);
    check("both_tag1", int'(bus.OUT_allocTag[1]), 35);
    check("both_free", int'(bus.OUT_freeCount), 30);
    check("model_both_state32", mState[32], 1);

    doReset();
    alloc1(1, 0);
    check("lane1_tag0", int'(bus.OUT_allocTag[0]), 33);
    check("lane1_tag1", int'(bus.OUT_allocTag[1]), 34);
    check("model_lane1_tag32", mState[32], 1);

    doReset();
    for (int j = 0; j < 8; j++) alloc2(5 + 2 * j, 6 + 2 * j);
    check("br_free_before", int'(bus.OUT_freeCount), 16);
    bus.IN_branchTaken = 1'b1; bus.IN_branchSqN = 6'd10;
    bus.IN_allocReq[0] = 1'b1; bus.IN_allocSqN[0] = 6'd21;
    step();
    check("br_free_after", int'(bus.OUT_freeCount), 26);
    check("br_tag0", int'(bus.OUT_allocTag[0]), 38);
    check("br_tag1", int'(bus.OUT_allocTag[1]), 39);
    check("model_br_tag37", mState[37], 1);

    doReset();
    for (int j = 0; j < 8; j++) alloc2(5 + 2 * j, 6 + 2 * j);
    commitLane(0, 40, 3, 13);
    commitLane(1, 41, 40, 14);
    step();
    check("com_tag0", int'(bus.OUT_allocTag[0]), 3);
    check("com_tag1", int'(bus.OUT_allocTag[1]), 40);
    check("com_free", int'(bus.OUT_freeCount), 18);
    check("com_error", int'(bus.OUT_error), 0);
    check("model_com_tag41", mState[41], 2);
    commitLane(0, 42, 3, 15);
    step();
    check("dblfree_error", int'(bus.OUT_error), 1);

    doReset();
    for (int j = 0; j < 15; j++) alloc2(2 * j, 2 * j + 1);
    alloc1(0, 30);
    check("empty_free", int'(bus.OUT_freeCount), 1);
    check("empty_ready", int'(bus.OUT_allocReady), 0);
    check("empty_tag0", int'(bus.OUT_allocTag[0]), 63);
    alloc1(0, 31);
    check("last_free", int'(bus.OUT_freeCount), 0);
    check("last_error", int'(bus.OUT_error), 0);
    alloc1(0, 32);
    check("over_error", int'(bus.OUT_error), 1);
    check("over_free", int'(bus.OUT_freeCount), 0);

    doReset();
    alloc2(58, 59);
    alloc2(60, 61);
    bus.IN_branchTaken = 1'b1; bus.IN_branchSqN = 6'd60;
    commitLane(0, 33, 5, 59);
    commitLane(1, 35, 6, 61);
    step();
    check("brcom_tag0", int'(bus.OUT_allocTag[0]), 5);
    check("brcom_tag1", int'(bus.OUT_allocTag[1]), 35);
    check("brcom_free", int'(bus.OUT_freeCount), 30);
    check("model_brcom_tag6", mState[6], 2);
    check("model_brcom_tag34", mState[34], 1);

    // Reset with live requests must still land in the reset state.
    alloc1(0, 62);
    bus.IN_allocReq[0] = 1'b1; bus.IN_allocReq[1] = 1'b1;
    commitLane(0, 33, 40, 59);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_tag0", int'(bus.OUT_allocTag[0]), 32);
    check("mrst_free", int'(bus.OUT_freeCount), 32);
    check("mrst_error", int'(bus.OUT_error), 0);
    step();

    checkEn = 1'b0;
    @(posedge clk);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
